led_code_receiver: RTL and testbench

Receiver for the LED blink code: samples a single-wire light/LED level and measures the high-pulse widths. Short pulses decode as 0 and long pulses as 1.
Bits are accumulated MSB first and presented as a parallel word with a one-cycle valid strobe.
Sits at a photodetector/test-fixture input; it is the decode end of the blink-code link.
Link format per bit, in slots of blink_period: low×2, high×1, data×3, low×2. Bit 0 is therefore a 1-slot high pulse and bit 1 is a 4-slot high pulse. Frames are separated by long low pauses.

---
 rtl/led_code_pkg.sv | 25 ++
 rtl/led_sync_edge.sv | 33 +++
 rtl/led_code_receiver.sv | 163 ++++++++++++++++
 tb/tb_led_code_receiver.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_code_pkg.sv
// Shared types and timing helpers for the LED blink-code receiver.
// Pulse-class thresholds are expressed as multiples of one blink slot.
package led_code_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    RX_HIGH,
    RX_LOW
  } state_t;

  localparam int unsigned CNT_W = 32;

  // Bit 0: SLOT/2 <= W < 2*SLOT.  Bit 1: 3*SLOT <= W < 5*SLOT.
  localparam int unsigned BIT0_MIN_DIV = 2;
  localparam int unsigned BIT0_MAX_MUL = 2;
  localparam int unsigned BIT1_MIN_MUL = 3;
  localparam int unsigned BIT1_MAX_MUL = 5;

  function automatic longint unsigned ms_to_ticks(input longint unsigned clock_freq,
                                                  input longint unsigned ms);
    return ms * (clock_freq / 64'd1000);
  endfunction

endpackage

// File: rtl/led_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, plus registered rise/fall
// strobes; level is delayed to stay aligned with the strobes.
module led_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic stable;

  // NOTE: every register here uses <= so all stages sample the pre-edge values;
  // blocking assignments would collapse the pipeline into a single flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= din;
      stable <= meta;
      level  <= stable;
      rise   <= stable & ~level;
      fall   <= ~stable & level;
    end
  end

endmodule

// File: rtl/led_code_receiver.sv
// LED blink-code receiver: classifies high-pulse widths into bits, MSB first.
// Optional build macro LED_CODE_RECEIVER_CHANGE_ONLY_EN suppresses repeated words.
module led_code_receiver
  import led_code_pkg::*;
#(
  parameter int unsigned clock_freq      = 50_000_000,
  parameter int unsigned blink_period_ms = 100,
  parameter int unsigned gap_ms          = 1_000,
  parameter int unsigned bits_count      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  serial_in,
  output logic [bits_count-1:0] code,
  output logic                  code_valid,
  output logic                  frame_error,
  output logic                  busy
);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   wide_t;

  localparam longint unsigned SLOT = ms_to_ticks(clock_freq, blink_period_ms);
  localparam longint unsigned GAP  = ms_to_ticks(clock_freq, gap_ms);

  localparam wide_t B0_MIN = wide_t'(SLOT / BIT0_MIN_DIV);
  localparam wide_t B0_MAX = wide_t'(SLOT * BIT0_MAX_MUL);
  localparam wide_t B1_MIN = wide_t'(SLOT * BIT1_MIN_MUL);
  localparam wide_t B1_MAX = wide_t'(SLOT * BIT1_MAX_MUL);
  localparam wide_t GAP_W  = wide_t'(GAP);

  localparam logic [5:0] IDX_INIT = 6'(bits_count - 1);

  logic level;
  logic rise;
  logic fall;

  led_sync_edge u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .din    (serial_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  state_t                state;
  cnt_t                  cnt;
  logic [5:0]            bit_idx;
  logic [bits_count-1:0] shreg;
`ifdef LED_CODE_RECEIVER_CHANGE_ONLY_EN
  logic                  have_code;
`endif

  wide_t                 width;
  cnt_t                  cnt_inc;
  logic                  is_bit0;
  logic                  is_bit1;
  logic [bits_count-1:0] shreg_next;
  logic                  publish;

  // The cycle on which an edge is seen belongs to the level being measured,
  // so the width of the current run is cnt + 1.
  // NOTE: every output of this block is assigned on every pass before any
  // conditional use, so no latch can be inferred.
  always_comb begin
    width      = {1'b0, cnt} + wide_t'(1);
    cnt_inc    = (cnt == '1) ? cnt : cnt + cnt_t'(1);
    is_bit0    = (width >= B0_MIN) && (width < B0_MAX);
    is_bit1    = (width >= B1_MIN) && (width < B1_MAX);
    shreg_next = shreg << 1;
    shreg_next[0] = is_bit1;
`ifdef LED_CODE_RECEIVER_CHANGE_ONLY_EN
    publish    = !have_code || (shreg_next != code);
`else
    publish    = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SYNC;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      code        <= '0;
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      busy        <= 1'b0;
`ifdef LED_CODE_RECEIVER_CHANGE_ONLY_EN
      have_code   <= 1'b0;
`endif
    end else begin
      code_valid  <= 1'b0;
      frame_error <= 1'b0;
      cnt         <= (rise || fall) ? '0 : cnt_inc;

      unique case (state)
        SYNC: begin
          // A fall this cycle means cnt still holds high time; ignore it.
          if (!level && !fall && (width >= GAP_W)) begin
            state <= IDLE;
            cnt   <= '0;
          end
        end

        IDLE: begin
          if (rise) begin
            state   <= RX_HIGH;
            bit_idx <= IDX_INIT;
            busy    <= 1'b1;
          end
        end

        RX_HIGH: begin
          if (fall) begin
            if (is_bit0 || is_bit1) begin
              shreg <= shreg_next;
              if (bit_idx == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
                if (publish) begin
                  code       <= shreg_next;
                  code_valid <= 1'b1;
`ifdef LED_CODE_RECEIVER_CHANGE_ONLY_EN
                  have_code  <= 1'b1;
`endif
                end
              end else begin
                bit_idx <= bit_idx - 6'd1;
                state   <= RX_LOW;
              end
            end else begin
              frame_error <= 1'b1;
              state       <= SYNC;
              busy        <= 1'b0;
            end
          end else if (width >= B1_MAX) begin
            frame_error <= 1'b1;
            state       <= SYNC;
            busy        <= 1'b0;
            cnt         <= '0;
          end
        end

        RX_LOW: begin
          if (rise) begin
            state <= RX_HIGH;
          end else if (width >= GAP_W) begin
            // Truncated frame: the long low already marks a fresh boundary.
            frame_error <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
            cnt         <= '0;
          end
        end

        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_led_code_receiver.sv
// Self-checking bench for led_code_receiver: plays pulse/low sequences and
// compares observed strobes against a pulse-level model of the link rules.
module tb_led_code_receiver;

  localparam int SLOT  = 10;
  localparam int GAP   = 100;
  localparam int NBITS = 8;

`ifdef LED_CODE_RECEIVER_CHANGE_ONLY_EN
  localparam bit CHANGE_ONLY = 1'b1;
`else
  localparam bit CHANGE_ONLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       serial_in;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_error;
  logic       busy;

  always #5 clk = ~clk;

  led_code_receiver #(
    .clock_freq     (10_000),
    .blink_period_ms(1),
    .gap_ms         (10),
    .bits_count     (NBITS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .serial_in  (serial_in),
    .code       (code),
    .code_valid (code_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  typedef struct packed {
    logic        is_err;
    logic [31:0] cyc;
    logic [7:0]  word;
  } ev_t;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  ev_t  got_q[$];
  ev_t  exp_q[$];
  int   hi_q[$];
  int   lo_q[$];
  int   rise_c[$];
  int   fall_c[$];

  bit         m_synced;
  bit         m_have;
  logic [7:0] m_code;
  logic [7:0] m_word;
  int         m_idx;

  function automatic ev_t mk_ev(input logic e, input int c, input logic [7:0] w);
    ev_t ev;
    ev.is_err = e;
    ev.cyc    = c;
    ev.word   = w;
    return ev;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (code_valid)  got_q.push_back(mk_ev(1'b0, cyc, code));
    if (frame_error) got_q.push_back(mk_ev(1'b1, cyc, code));
  end

  // ---------------- reference model ----------------
  function automatic int classify(input int w);
    if (w >= SLOT / 2 && w < 2 * SLOT) return 0;
    if (w >= 3 * SLOT && w < 5 * SLOT) return 1;
    return -1;
  endfunction

  function automatic void model_reset();
    m_synced = 1'b0;
    m_have   = 1'b0;
    m_code   = 8'h00;
    m_word   = 8'h00;
    m_idx    = 0;
  endfunction

  function automatic void model_low(input int len);
    if (len > GAP) m_synced = 1'b1;
  endfunction

  // Walks the played pulses: events are timed from the drive cycle of the
  // relevant edge plus the 4-cycle sync/detect/register latency.
  function automatic void model_run();
    for (int i = 0; i < hi_q.size(); i++) begin
      int cls;
      if (!m_synced) begin
        model_low(lo_q[i]);
        continue;
      end
      if (hi_q[i] >= 5 * SLOT) begin
        exp_q.push_back(mk_ev(1'b1, rise_c[i] + 5 * SLOT + 4, m_code));
        m_idx = 0;
        m_synced = (lo_q[i] > GAP);
        continue;
      end
      cls = classify(hi_q[i]);
      if (cls < 0) begin
        exp_q.push_back(mk_ev(1'b1, fall_c[i] + 4, m_code));
        m_idx = 0;
        m_synced = (lo_q[i] > GAP);
        continue;
      end
      m_word = (m_word << 1) | 8'(cls);
      m_idx++;
      if (m_idx == NBITS) begin
        if (!CHANGE_ONLY || !m_have || m_word != m_code) begin
          m_code = m_word;
          m_have = 1'b1;
          exp_q.push_back(mk_ev(1'b0, fall_c[i] + 4, m_code));
        end
        m_idx = 0;
      end else if (lo_q[i] > GAP) begin
        exp_q.push_back(mk_ev(1'b1, fall_c[i] + GAP + 4, m_code));
        m_idx = 0;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic hold(input logic v, input int n);
    serial_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic new_seq();
    got_q.delete();
    exp_q.delete();
    hi_q.delete();
    lo_q.delete();
    rise_c.delete();
    fall_c.delete();
  endtask

  task automatic add_pulse(input int hi, input int lo);
    hi_q.push_back(hi);
    lo_q.push_back(lo);
  endtask

  task automatic add_frame(input logic [7:0] w, input int trailing);
    for (int b = 7; b >= 0; b--) begin
      if (w[b]) add_pulse(4 * SLOT, (b == 0) ? trailing : 4 * SLOT);
      else      add_pulse(SLOT, (b == 0) ? trailing : 7 * SLOT);
    end
  endtask

  task automatic add_rand_frame(input logic [7:0] w, input int trailing);
    for (int b = 7; b >= 0; b--) begin
      int hi;
      hi = w[b] ? int'($urandom_range(30, 49)) : int'($urandom_range(5, 19));
      add_pulse(hi, (b == 0) ? trailing : int'($urandom_range(10, 90)));
    end
  endtask

  task automatic play_pulse(input int i);
    rise_c.push_back(cyc);
    hold(1'b1, hi_q[i]);
    fall_c.push_back(cyc);
    hold(1'b0, lo_q[i]);
  endtask

  task automatic play_all();
    for (int i = rise_c.size(); i < hi_q.size(); i++) play_pulse(i);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n   = 1'b0;
    serial_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (code !== 8'h00 || code_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: code=%h valid=%b err=%b busy=%b, want all 0",
               code, code_valid, frame_error, busy);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (code !== 8'h00 || code_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: code=%h valid=%b err=%b busy=%b, want all 0",
               code, code_valid, frame_error, busy);
    end
    model_reset();
  endtask

  task automatic test_single_frame();
    new_seq();
    hold(1'b0, 120);
    model_low(120);
    add_frame(8'hA5, 200);
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL single_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL single_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    checks++;
    if (code !== 8'hA5) begin
      failures++;
      $display("FAIL single_code: got %h, want a5", code);
    end
  endtask

  task automatic test_back_to_back();
    int n_valid;
    new_seq();
    add_frame(8'h3C, 200);
    add_frame(8'h3C, 200);
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL b2b_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL b2b_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    n_valid = 0;
    foreach (got_q[i]) if (!got_q[i].is_err) n_valid++;
    checks++;
    if (n_valid != (CHANGE_ONLY ? 1 : 2) || code !== 8'h3C) begin
      failures++;
      $display("FAIL b2b_strobes: got %0d strobes code=%h, want %0d strobes code=3c",
               n_valid, code, CHANGE_ONLY ? 1 : 2);
    end
  endtask

  task automatic test_boundaries();
    int n_err;
    new_seq();
    add_pulse(5, 70);
    add_pulse(19, 70);
    add_pulse(30, 40);
    add_pulse(49, 40);
    add_pulse(10, 70);
    add_pulse(40, 40);
    add_pulse(10, 70);
    add_pulse(40, 150);
    add_pulse(4, 150);
    add_pulse(20, 150);
    add_pulse(29, 150);
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bound_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bound_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    n_err = 0;
    foreach (got_q[i]) if (got_q[i].is_err) n_err++;
    checks++;
    if (n_err != 3 || code !== 8'h35) begin
      failures++;
      $display("FAIL bound_summary: got %0d errors code=%h, want 3 errors code=35", n_err, code);
    end
  endtask

  task automatic test_stuck_high();
    new_seq();
    add_pulse(60, 60);
    add_frame(8'hC3, 150);
    add_pulse(60, 110);
    add_frame(8'h5A, 150);
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL stuck_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL stuck_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    checks++;
    if (code !== 8'h5A) begin
      failures++;
      $display("FAIL stuck_code: got %h, want 5a", code);
    end
  endtask

  task automatic test_truncated();
    new_seq();
    add_pulse(40, 40);
    add_pulse(10, 70);
    add_pulse(40, 40);
    add_pulse(40, 40);
    add_pulse(10, 150);
    add_frame(8'h01, 150);
    for (int i = 0; i < 4; i++) play_pulse(i);
    rise_c.push_back(cyc);
    hold(1'b1, hi_q[4]);
    fall_c.push_back(cyc);
    hold(1'b0, 50);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL trunc_busy_mid: got %b, want 1", busy);
    end
    hold(1'b0, lo_q[4] - 50);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL trunc_busy_after: got %b, want 0", busy);
    end
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL trunc_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL trunc_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    checks++;
    if (code !== 8'h01) begin
      failures++;
      $display("FAIL trunc_code: got %h, want 01", code);
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] w;
    w = 8'(($urandom));
    new_seq();
    for (int f = 0; f < 8; f++) begin
      int trailing;
      if ($urandom_range(0, 2) != 0) w = 8'($urandom);
      trailing = (f == 7 || $urandom_range(0, 1) == 1) ? int'($urandom_range(120, 200))
                                                      : int'($urandom_range(20, 80));
      add_rand_frame(w, trailing);
    end
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rand_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    checks++;
    if (code !== m_code) begin
      failures++;
      $display("FAIL rand_code: got %h, want %h", code, m_code);
    end
  endtask

  task automatic test_reset_mid_frame();
    new_seq();
    add_frame(8'h96, 150);
    for (int i = 0; i < 3; i++) play_pulse(i);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_busy_before: got %b, want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (code !== 8'h00 || code_valid !== 1'b0 || frame_error !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_async: code=%h valid=%b err=%b busy=%b, want all 0",
               code, code_valid, frame_error, busy);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    new_seq();
    hold(1'b0, 120);
    model_low(120);
    add_frame(8'hFF, 150);
    play_all();
    model_run();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rstmid_count: got %0d events, want %0d", got_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rstmid_ev%0d: got err=%b cyc=%0d code=%h, want err=%b cyc=%0d code=%h", i,
                 got_q[i].is_err, got_q[i].cyc, got_q[i].word, exp_q[i].is_err, exp_q[i].cyc, exp_q[i].word);
      end
    end
    checks++;
    if (code !== 8'hFF) begin
      failures++;
      $display("FAIL rstmid_code: got %h, want ff", code);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_boundaries();
    test_stuck_high();
    test_truncated();
    test_random_frames();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
